fwrisc_dbus_responder: RTL and testbench

Target (responder) end of the fwrisc data bus (daddr/dwdata/drdata/dstrb/dwrite/dvalid/dready). It replaces the always-ready data port tie-off in benches and SoC shells. It provides a byte-strobed word SRAM, a test mailbox register, and run-time programmable wait states, so core stall handling can be exercised. Accesses that decode to neither region complete with an error flag.

---
 rtl/fwrisc_dbus_responder.sv | 136 +++++++++++++
 tb/tb_fwrisc_dbus_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_dbus_responder.sv
// fwrisc data-bus responder: byte-strobed word SRAM, test mailbox and
// programmable wait states. Unmapped accesses complete with derr.
module fwrisc_dbus_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
  parameter logic [31:0] MBOX_ADDR  = 32'hF000_0000,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dstrb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        derr,
  input  logic [3:0]  wait_cfg,
  output logic        done,
  output logic [31:0] status,
  output logic [31:0] xfer_count
);

  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Latched request plus its decode; the bus inputs are not looked at
  // again once a transfer has been accepted.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wdata;
    logic [3:0]            strb;
    logic                  write;
    logic                  sram;
    logic                  mbox;
  } req_t;

  state_t state, state_n;
  req_t   req_in, req_q, req_cur;
  logic [3:0]  cnt;
  logic [31:0] rd_val;
  logic        accept, enter_resp, complete;
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  // Byte offset is irrelevant: lanes are chosen by dstrb alone.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^daddr[1:0];

  // Decode the live bus request; SRAM wins if the windows ever overlap.
  always_comb begin
    req_in       = '0;
    req_in.idx   = daddr[ADDR_WIDTH+1:2];
    req_in.wdata = dwdata;
    req_in.strb  = dstrb;
    req_in.write = dwrite;
    req_in.sram  = (daddr[31:ADDR_WIDTH+2] == MEM_BASE[31:ADDR_WIDTH+2]);
    req_in.mbox  = !req_in.sram && (daddr[31:2] == MBOX_ADDR[31:2]);
  end

  // Next state; a zero wait count goes straight from IDLE to RESP.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (dvalid) state_n = (wait_cfg == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && dvalid;
  assign enter_resp = (state != RESP) && (state_n == RESP);
  assign complete   = (state == RESP);
  assign dready     = complete;
  assign derr       = complete && !req_q.sram && !req_q.mbox;

  // With no wait states the read data is captured on the accept edge, so the
  // read source is the live request in IDLE and the latched one afterwards.
  assign req_cur = (state == IDLE) ? req_in : req_q;

  // Read data selection; writes return zero.
  always_comb begin
    rd_val = '0;
    if (!req_cur.write) begin
      if (req_cur.sram)      rd_val = mem[req_cur.idx];
      else if (req_cur.mbox) rd_val = status;
      else                   rd_val = ERR_DATA;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Request latch, wait counter, read data, mailbox and transfer counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q      <= '0;
      cnt        <= '0;
      drdata     <= '0;
      done       <= 1'b0;
      status     <= '0;
      xfer_count <= '0;
    end else begin
      if (accept) begin
        req_q <= req_in;
        cnt   <= wait_cfg;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) drdata <= rd_val;
      if (complete) begin
        xfer_count <= xfer_count + 32'd1;
        if (req_q.write && req_q.mbox) begin
          done <= 1'b1;
          for (int l = 0; l < NUM_LANES; l++)
            if (req_q.strb[l]) status[8*l +: 8] <= req_q.wdata[8*l +: 8];
        end
      end
    end
  end

  // SRAM byte-lane writes at completion; contents are deliberately not reset,
  // and an async reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (complete && req_q.write && req_q.sram)
      for (int l = 0; l < NUM_LANES; l++)
        if (req_q.strb[l]) mem[req_q.idx][l] <= req_q.wdata[8*l +: 8];
  end

endmodule

// File: tb/tb_fwrisc_dbus_responder.sv
// Scoreboard bench for fwrisc_dbus_responder: driver pushes expected
// responses computed from an address-map model, monitor pops on dready.
module tb_fwrisc_dbus_responder;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clock, reset;
  logic [31:0] daddr, dwdata, drdata, status, xfer_count;
  logic [3:0]  dstrb, wait_cfg;
  logic        dwrite, dvalid, dready, derr, done;

  fwrisc_dbus_responder dut (
    .clock(clock), .reset(reset), .daddr(daddr), .dwdata(dwdata),
    .dstrb(dstrb), .dwrite(dwrite), .dvalid(dvalid), .dready(dready),
    .drdata(drdata), .derr(derr), .wait_cfg(wait_cfg), .done(done),
    .status(status), .xfer_count(xfer_count)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          is_rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[int];
  logic [31:0] m_status, m_count;
  logic        m_done;
  int          cyc, total, bad;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Issue one transfer; model decides the response from the address map.
  task automatic do_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, input int wc, input int wc_mid, input bit drop);
    exp_t e;
    int   n, idx;
    e.is_rd = !w; e.err = 1'b0; e.rd = '0;
    if ((a >> 14) == 0) begin
      idx = int'(a[13:2]);
      if (w) mdl[idx] = merge(mdl.exists(idx) ? mdl[idx] : 32'h0, d, s);
      else if (mdl.exists(idx)) e.rd = mdl[idx];
      else e.is_rd = 0;
    end else if ((a >> 2) == (32'hF000_0000 >> 2)) begin
      if (w) begin m_status = merge(m_status, d, s); m_done = 1'b1; end
      else e.rd = m_status;
    end else begin
      e.err = 1'b1;
      e.rd  = ERR_DATA;
    end
    m_count++;
    e.cyc = cyc + 1 + wc;
    sb.push_back(e);
    daddr = a; dwdata = d; dstrb = s; dwrite = w; wait_cfg = 4'(wc); dvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      if (n == 0 && wc_mid >= 0) wait_cfg = 4'(wc_mid);
      if (n == 0 && drop) dvalid = 1'b0;
      n++;
    end while (!dready && n < 40);
    if (!dready) begin
      total++; bad++;
      $display("FAIL timeout: no dready for addr %h within 40 cycles", a);
    end
    dvalid = 1'b0;
    @(negedge clock);
  endtask

  // Monitor: each dready cycle consumes exactly one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && dready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_dready: got dready=1 expected no response");
        end else begin
          e = sb.pop_front();
          chk("dready_cycle", cyc, e.cyc);
          chk("derr", {31'b0, derr}, {31'b0, e.err});
          if (e.is_rd) chk("drdata", drdata, e.rd);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int k;
    cyc = 0; total = 0; bad = 0;
    m_status = '0; m_done = 0; m_count = '0;
    daddr = '0; dwdata = '0; dstrb = '0; dwrite = 0; dvalid = 0; wait_cfg = '0;
    reset = 1;
    #1 reset = 0;
    repeat (3) @(negedge clock);
    chk("rst_dready", {31'b0, dready}, 32'h0);
    chk("rst_derr", {31'b0, derr}, 32'h0);
    chk("rst_drdata", drdata, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_xfer_count", xfer_count, 32'h0);
    reset = 1;
    @(negedge clock);

    // Basic write/read, zero wait states.
    do_xfer(32'h100, 32'h1234_5678, 4'hF, 1, 0, -1, 0);
    do_xfer(32'h100, 32'h0, 4'hF, 0, 0, -1, 0);
    chk("xfer_count_2", xfer_count, 32'd2);

    // Byte strobes.
    do_xfer(32'h100, 32'hAABB_CCDD, 4'b0101, 1, 0, -1, 0);
    do_xfer(32'h100, 32'h0, 4'h0, 0, 0, -1, 0);

    // Five wait states; lowering wait_cfg mid-transfer must not shorten it.
    do_xfer(32'h100, 32'h0, 4'hF, 0, 5, 0, 0);

    // Decode errors, read then write; nothing may change.
    do_xfer(32'h0001_0000, 32'h0, 4'hF, 0, 0, -1, 0);
    do_xfer(32'h0001_0000, 32'h5555_5555, 4'hF, 1, 0, -1, 0);
    do_xfer(32'h100, 32'h0, 4'hF, 0, 0, -1, 0);
    chk("err_status", status, 32'h0);
    chk("err_done", {31'b0, done}, 32'h0);

    // Mailbox.
    do_xfer(32'hF000_0000, 32'h0000_0001, 4'hF, 1, 0, -1, 0);
    chk("mbox_done", {31'b0, done}, 32'h1);
    chk("mbox_status", status, 32'h1);
    do_xfer(32'hF000_0000, 32'h0, 4'hF, 0, 0, -1, 0);

    // Randomized traffic over a small initialized window.
    for (int i = 0; i < 16; i++) do_xfer(32'h100 + 32'(4*i), $urandom, 4'hF, 1, 0, -1, 0);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7)       a = 32'h100 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (k == 7) a = 32'hF000_0000 + 32'($urandom_range(0, 3));
      else if (k == 8) a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else             a = 32'hF000_0004;
      do_xfer(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1,
              1'($urandom_range(0, 1)));
    end
    chk("rand_xfer_count", xfer_count, m_count);
    chk("rand_status", status, m_status);
    chk("rand_done", {31'b0, done}, {31'b0, m_done});

    // Reset in the middle of a waited write to 0x200.
    do_xfer(32'h200, 32'h0BAD_F00D, 4'hF, 1, 0, -1, 0);
    daddr = 32'h200; dwdata = 32'hFFFF_FFFF; dstrb = 4'hF; dwrite = 1; wait_cfg = 4'd3;
    dvalid = 1;
    @(negedge clock);
    dvalid = 0;
    @(negedge clock);
    reset = 0;
    #1;
    chk("abort_dready", {31'b0, dready}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_xfer_count", xfer_count, 32'h0);
    m_status = '0; m_done = 0; m_count = '0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    do_xfer(32'h200, 32'h0, 4'hF, 0, 0, -1, 0);
    chk("post_rst_xfer_count", xfer_count, m_count);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
